// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants and the
// linear-layer helpers (xtime, MixColumns on one column, ShiftRows).
package aes_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are ordered row 0 in [31:24] down to row 3 in [7:0].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte k = 4*col + row lives at bits [127-8k -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] q
);
    always_comb begin
        q = 8'h00;
        case (a)
            8'h00: q = 8'h63; 8'h01: q = 8'h7c; 8'h02: q = 8'h77; 8'h03: q = 8'h7b;
            8'h04: q = 8'hf2; 8'h05: q = 8'h6b; 8'h06: q = 8'h6f; 8'h07: q = 8'hc5;
            8'h08: q = 8'h30; 8'h09: q = 8'h01; 8'h0a: q = 8'h67; 8'h0b: q = 8'h2b;
            8'h0c: q = 8'hfe; 8'h0d: q = 8'hd7; 8'h0e: q = 8'hab; 8'h0f: q = 8'h76;
            8'h10: q = 8'hca; 8'h11: q = 8'h82; 8'h12: q = 8'hc9; 8'h13: q = 8'h7d;
            8'h14: q = 8'hfa; 8'h15: q = 8'h59; 8'h16: q = 8'h47; 8'h17: q = 8'hf0;
            8'h18: q = 8'had; 8'h19: q = 8'hd4; 8'h1a: q = 8'ha2; 8'h1b: q = 8'haf;
            8'h1c: q = 8'h9c; 8'h1d: q = 8'ha4; 8'h1e: q = 8'h72; 8'h1f: q = 8'hc0;
            8'h20: q = 8'hb7; 8'h21: q = 8'hfd; 8'h22: q = 8'h93; 8'h23: q = 8'h26;
            8'h24: q = 8'h36; 8'h25: q = 8'h3f; 8'h26: q = 8'hf7; 8'h27: q = 8'hcc;
            8'h28: q = 8'h34; 8'h29: q = 8'ha5; 8'h2a: q = 8'he5; 8'h2b: q = 8'hf1;
            8'h2c: q = 8'h71; 8'h2d: q = 8'hd8; 8'h2e: q = 8'h31; 8'h2f: q = 8'h15;
            8'h30: q = 8'h04; 8'h31: q = 8'hc7; 8'h32: q = 8'h23; 8'h33: q = 8'hc3;
            8'h34: q = 8'h18; 8'h35: q = 8'h96; 8'h36: q = 8'h05; 8'h37: q = 8'h9a;
            8'h38: q = 8'h07; 8'h39: q = 8'h12; 8'h3a: q = 8'h80; 8'h3b: q = 8'he2;
            8'h3c: q = 8'heb; 8'h3d: q = 8'h27; 8'h3e: q = 8'hb2; 8'h3f: q = 8'h75;
            8'h40: q = 8'h09; 8'h41: q = 8'h83; 8'h42: q = 8'h2c; 8'h43: q = 8'h1a;
            8'h44: q = 8'h1b; 8'h45: q = 8'h6e; 8'h46: q = 8'h5a; 8'h47: q = 8'ha0;
            8'h48: q = 8'h52; 8'h49: q = 8'h3b; 8'h4a: q = 8'hd6; 8'h4b: q = 8'hb3;
            8'h4c: q = 8'h29; 8'h4d: q = 8'he3; 8'h4e: q = 8'h2f; 8'h4f: q = 8'h84;
            8'h50: q = 8'h53; 8'h51: q = 8'hd1; 8'h52: q = 8'h00; 8'h53: q = 8'hed;
            8'h54: q = 8'h20; 8'h55: q = 8'hfc; 8'h56: q = 8'hb1; 8'h57: q = 8'h5b;
            8'h58: q = 8'h6a; 8'h59: q = 8'hcb; 8'h5a: q = 8'hbe; 8'h5b: q = 8'h39;
            8'h5c: q = 8'h4a; 8'h5d: q = 8'h4c; 8'h5e: q = 8'h58; 8'h5f: q = 8'hcf;
            8'h60: q = 8'hd0; 8'h61: q = 8'hef; 8'h62: q = 8'haa; 8'h63: q = 8'hfb;
            8'h64: q = 8'h43; 8'h65: q = 8'h4d; 8'h66: q = 8'h33; 8'h67: q = 8'h85;
            8'h68: q = 8'h45; 8'h69: q = 8'hf9; 8'h6a: q = 8'h02; 8'h6b: q = 8'h7f;
            8'h6c: q = 8'h50; 8'h6d: q = 8'h3c; 8'h6e: q = 8'h9f; 8'h6f: q = 8'ha8;
            8'h70: q = 8'h51; 8'h71: q = 8'ha3; 8'h72: q = 8'h40; 8'h73: q = 8'h8f;
            8'h74: q = 8'h92; 8'h75: q = 8'h9d; 8'h76: q = 8'h38; 8'h77: q = 8'hf5;
            8'h78: q = 8'hbc; 8'h79: q = 8'hb6; 8'h7a: q = 8'hda; 8'h7b: q = 8'h21;
            8'h7c: q = 8'h10; 8'h7d: q = 8'hff; 8'h7e: q = 8'hf3; 8'h7f: q = 8'hd2;
            8'h80: q = 8'hcd; 8'h81: q = 8'h0c; 8'h82: q = 8'h13; 8'h83: q = 8'hec;
            8'h84: q = 8'h5f; 8'h85: q = 8'h97; 8'h86: q = 8'h44; 8'h87: q = 8'h17;
            8'h88: q = 8'hc4; 8'h89: q = 8'ha7; 8'h8a: q = 8'h7e; 8'h8b: q = 8'h3d;
            8'h8c: q = 8'h64; 8'h8d: q = 8'h5d; 8'h8e: q = 8'h19; 8'h8f: q = 8'h73;
            8'h90: q = 8'h60; 8'h91: q = 8'h81; 8'h92: q = 8'h4f; 8'h93: q = 8'hdc;
            8'h94: q = 8'h22; 8'h95: q = 8'h2a; 8'h96: q = 8'h90; 8'h97: q = 8'h88;
            8'h98: q = 8'h46; 8'h99: q = 8'hee; 8'h9a: q = 8'hb8; 8'h9b: q = 8'h14;
            8'h9c: q = 8'hde; 8'h9d: q = 8'h5e; 8'h9e: q = 8'h0b; 8'h9f: q = 8'hdb;
            8'ha0: q = 8'he0; 8'ha1: q = 8'h32; 8'ha2: q = 8'h3a; 8'ha3: q = 8'h0a;
            8'ha4: q = 8'h49; 8'ha5: q = 8'h06; 8'ha6: q = 8'h24; 8'ha7: q = 8'h5c;
            8'ha8: q = 8'hc2; 8'ha9: q = 8'hd3; 8'haa: q = 8'hac; 8'hab: q = 8'h62;
            8'hac: q = 8'h91; 8'had: q = 8'h95; 8'hae: q = 8'he4; 8'haf: q = 8'h79;
            8'hb0: q = 8'he7; 8'hb1: q = 8'hc8; 8'hb2: q = 8'h37; 8'hb3: q = 8'h6d;
            8'hb4: q = 8'h8d; 8'hb5: q = 8'hd5; 8'hb6: q = 8'h4e; 8'hb7: q = 8'ha9;
            8'hb8: q = 8'h6c; 8'hb9: q = 8'h56; 8'hba: q = 8'hf4; 8'hbb: q = 8'hea;
            8'hbc: q = 8'h65; 8'hbd: q = 8'h7a; 8'hbe: q = 8'hae; 8'hbf: q = 8'h08;
            8'hc0: q = 8'hba; 8'hc1: q = 8'h78; 8'hc2: q = 8'h25; 8'hc3: q = 8'h2e;
            8'hc4: q = 8'h1c; 8'hc5: q = 8'ha6; 8'hc6: q = 8'hb4; 8'hc7: q = 8'hc6;
            8'hc8: q = 8'he8; 8'hc9: q = 8'hdd; 8'hca: q = 8'h74; 8'hcb: q = 8'h1f;
            8'hcc: q = 8'h4b; 8'hcd: q = 8'hbd; 8'hce: q = 8'h8b; 8'hcf: q = 8'h8a;
            8'hd0: q = 8'h70; 8'hd1: q = 8'h3e; 8'hd2: q = 8'hb5; 8'hd3: q = 8'h66;
            8'hd4: q = 8'h48; 8'hd5: q = 8'h03; 8'hd6: q = 8'hf6; 8'hd7: q = 8'h0e;
            8'hd8: q = 8'h61; 8'hd9: q = 8'h35; 8'hda: q = 8'h57; 8'hdb: q = 8'hb9;
            8'hdc: q = 8'h86; 8'hdd: q = 8'hc1; 8'hde: q = 8'h1d; 8'hdf: q = 8'h9e;
            8'he0: q = 8'he1; 8'he1: q = 8'hf8; 8'he2: q = 8'h98; 8'he3: q = 8'h11;
            8'he4: q = 8'h69; 8'he5: q = 8'hd9; 8'he6: q = 8'h8e; 8'he7: q = 8'h94;
            8'he8: q = 8'h9b; 8'he9: q = 8'h1e; 8'hea: q = 8'h87; 8'heb: q = 8'he9;
            8'hec: q = 8'hce; 8'hed: q = 8'h55; 8'hee: q = 8'h28; 8'hef: q = 8'hdf;
            8'hf0: q = 8'h8c; 8'hf1: q = 8'ha1; 8'hf2: q = 8'h89; 8'hf3: q = 8'h0d;
            8'hf4: q = 8'hbf; 8'hf5: q = 8'he6; 8'hf6: q = 8'h42; 8'hf7: q = 8'h68;
            8'hf8: q = 8'h41; 8'hf9: q = 8'h99; 8'hfa: q = 8'h2d; 8'hfb: q = 8'h0f;
            8'hfc: q = 8'hb0; 8'hfd: q = 8'h54; 8'hfe: q = 8'hbb; 8'hff: q = 8'h16;
            default: q = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on
// the fly, valid/ready handshake on both sides.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] new_block
);
    if (NR != 10) begin : gen_nr_check
        $error("aes_enc_iter supports only NR = 10");
    end

    state_t       fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;

    logic [127:0] sub_state;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] next_key;
    logic [127:0] round_out;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  key_temp;

    for (genvar i = 0; i < 16; i++) begin : gen_state_sbox
        aes_sbox u_sbox (
            .a (state_reg[127-8*i -: 8]),
            .q (sub_state[127-8*i -: 8])
        );
    end

    assign rot_word = {key_reg[23:0], key_reg[31:24]};

    for (genvar i = 0; i < 4; i++) begin : gen_key_sbox
        aes_sbox u_sbox (
            .a (rot_word[31-8*i -: 8]),
            .q (sub_word[31-8*i -: 8])
        );
    end

    always_comb begin
        key_temp            = sub_word ^ {rcon(rnd), 24'h000000};
        next_key[127:96]    = key_reg[127:96] ^ key_temp;
        next_key[95:64]     = key_reg[95:64] ^ next_key[127:96];
        next_key[63:32]     = key_reg[63:32] ^ next_key[95:64];
        next_key[31:0]      = key_reg[31:0] ^ next_key[63:32];
        shifted             = shift_rows(sub_state);
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
        // Final round skips MixColumns.
        round_out = ((rnd == 4'(NR)) ? shifted : mixed) ^ next_key;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            new_block <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            rnd       <= '0;
        end else begin
            unique case (fsm)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        state_reg <= block ^ key;
                        key_reg   <= key;
                        rnd       <= 4'd1;
                        in_ready  <= 1'b0;
                        fsm       <= StRun;
                    end
                end
                StRun: begin
                    state_reg <= round_out;
                    key_reg   <= next_key;
                    rnd       <= rnd + 4'd1;
                    if (rnd == 4'(NR)) begin
                        new_block <= round_out;
                        out_valid <= 1'b1;
                        fsm       <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= StIdle;
                    end
                end
                default: fsm <= StIdle;
            endcase
        end
    end
endmodule
